// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase indices, duration limits/defaults and config FSM states
package traffic_pkg;
    localparam int TIME_W = 6;
    localparam int NUM_PHASES = 6;
    localparam int T_MIN = 3;
    localparam int T_MAX = 60;
    localparam int DEF_LEFT = 15;
    localparam int DEF_STRA = 30;
    localparam int DEF_RIGHT = 10;
    localparam logic [2:0] PH_EW_LEFT = 3'd0;
    localparam logic [2:0] PH_EW_STRA = 3'd1;
    localparam logic [2:0] PH_EW_RIGHT = 3'd2;
    localparam logic [2:0] PH_SN_LEFT = 3'd3;
    localparam logic [2:0] PH_SN_STRA = 3'd4;
    localparam logic [2:0] PH_SN_RIGHT = 3'd5;
    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_LOCK} cfg_state_e;
    function automatic logic [TIME_W-1:0] def_time(input int i);
        return (i % 3 == 0) ? TIME_W'(DEF_LEFT) : (i % 3 == 1) ? TIME_W'(DEF_STRA) : TIME_W'(DEF_RIGHT);
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; bit 0 wins the first tie after reset
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_q, last_d;
    always_comb begin
        gnt = !en ? 2'b00 : (&req) ? (last_q ? 2'b01 : 2'b10) : req;
        last_d = (|gnt) ? gnt[1] : last_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= 1'b1;
        else last_q <= last_d;
endmodule

// File: rtl/phase_time_cfg.sv
// phase_time_cfg: arbitrated, clamped phase-duration writes committed atomically at cycle start
module phase_time_cfg
    import traffic_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [2:0]        key_idx,
    input  logic [TIME_W-1:0] key_time,
    input  logic              rmt_valid,
    output logic              rmt_ready,
    input  logic [2:0]        rmt_idx,
    input  logic [TIME_W-1:0] rmt_time,
    input  logic              cycle_start,
    input  logic              emergency,
    output logic [TIME_W-1:0] ew_left_time,
    output logic [TIME_W-1:0] ew_stra_time,
    output logic [TIME_W-1:0] ew_right_time,
    output logic [TIME_W-1:0] sn_left_time,
    output logic [TIME_W-1:0] sn_stra_time,
    output logic [TIME_W-1:0] sn_right_time,
    output logic              pending,
    output logic              err_pulse
);
    if (T_MIN > T_MAX || T_MAX > 2**TIME_W - 1) begin : g_bad_limits
        $error("phase_time_cfg: duration limits out of range");
    end
    cfg_state_e state_q, state_d;
    logic [TIME_W-1:0] shadow_q [NUM_PHASES];
    logic [TIME_W-1:0] shadow_d [NUM_PHASES];
    logic [TIME_W-1:0] active_q [NUM_PHASES];
    logic [TIME_W-1:0] active_d [NUM_PHASES];
    logic pending_q, pending_d, err_q, err_d;
    logic [1:0] gnt;
    logic arb_en, wr, commit;
    logic [2:0] sel_idx;
    logic [TIME_W-1:0] sel_time, clamped;
    assign arb_en = !sys_rst && !emergency && state_q != ST_LOCK;
    rr_arb2 u_arb (
        .clk(sys_clk),
        .rst(sys_rst),
        .en (arb_en),
        .req({rmt_valid, key_valid}),
        .gnt(gnt)
    );
    assign key_ready = gnt[0];
    assign rmt_ready = gnt[1];
    always_comb begin
        sel_idx = gnt[1] ? rmt_idx : key_idx;
        sel_time = gnt[1] ? rmt_time : key_time;
        clamped = sel_time < TIME_W'(T_MIN) ? TIME_W'(T_MIN) : sel_time > TIME_W'(T_MAX) ? TIME_W'(T_MAX) : sel_time;
        wr = (|gnt) && sel_idx < 3'(NUM_PHASES);
        err_d = (|gnt) && (!wr || clamped != sel_time);
        // commit reads shadow_q, so a same-edge write is deferred to the next commit
        commit = cycle_start && pending_q && !emergency && state_q != ST_LOCK;
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_PHASES; i++)
            if (wr && sel_idx == 3'(i)) shadow_d[i] = clamped;
        active_d = commit ? shadow_q : active_q;
        pending_d = wr || (pending_q && !commit);
        state_d = emergency ? ST_LOCK : pending_d ? ST_PENDING : ST_IDLE;
    end
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state_q <= ST_IDLE;
            pending_q <= 1'b0;
            err_q <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                shadow_q[i] <= def_time(i);
                active_q[i] <= def_time(i);
            end
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            err_q <= err_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    assign ew_left_time = active_q[PH_EW_LEFT];
    assign ew_stra_time = active_q[PH_EW_STRA];
    assign ew_right_time = active_q[PH_EW_RIGHT];
    assign sn_left_time = active_q[PH_SN_LEFT];
    assign sn_stra_time = active_q[PH_SN_STRA];
    assign sn_right_time = active_q[PH_SN_RIGHT];
    assign pending = pending_q;
    assign err_pulse = err_q;
endmodule
